// File: rtl/vp_bbox_overlay.sv
// vp_bbox_overlay: tracks the bounding box of bright pixels per frame and
// paints the previous frame's box outline red over the video stream.
// Ports: clk, rst_n (sync, active low); de_in/h_sync_in/v_sync_in timing;
//   pixel_in {R,G,B}; mode channel select (0 R, 1 G, 2 B, 3 mean);
//   de_out/h_sync_out/v_sync_out/pixel_out delayed 2 cycles;
//   bbox_valid, x_min, x_max, y_min, y_max latched at each frame start.
// Option: define VP_BBOX_CROSS_EN to also paint a crosshair inside the box.
module vp_bbox_overlay #(
  parameter int H_ACT = 64,
  parameter int V_ACT = 64,
  parameter int COLOR_W = 8,
  parameter logic [COLOR_W-1:0] THRESH = COLOR_W'(128)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       de_in,
  input  logic                       h_sync_in,
  input  logic                       v_sync_in,
  input  logic [3*COLOR_W-1:0]       pixel_in,
  input  logic [1:0]                 mode,
  output logic                       de_out,
  output logic                       h_sync_out,
  output logic                       v_sync_out,
  output logic [3*COLOR_W-1:0]       pixel_out,
  output logic                       bbox_valid,
  output logic [$clog2(H_ACT)-1:0]   x_min,
  output logic [$clog2(H_ACT)-1:0]   x_max,
  output logic [$clog2(V_ACT)-1:0]   y_min,
  output logic [$clog2(V_ACT)-1:0]   y_max
);

  localparam int XW = $clog2(H_ACT);
  localparam int YW = $clog2(V_ACT);
  localparam int PW = 3 * COLOR_W;
  localparam int SW = COLOR_W + 9;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACT - 1);
  localparam logic [PW-1:0] RED =
    {{COLOR_W{1'b1}}, {(2 * COLOR_W){1'b0}}};

  logic          de_q, vs_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d, y_c;
  logic          found_q, found_d;
  logic [XW-1:0] rx0_q, rx0_d, rx1_q, rx1_d;
  logic [YW-1:0] ry0_q, ry0_d, ry1_q, ry1_d;
  logic          valid_q, valid_d;
  logic [XW-1:0] lx0_q, lx0_d, lx1_q, lx1_d;
  logic [YW-1:0] ly0_q, ly0_d, ly1_q, ly1_d;
  logic          s1_de_q, s1_hs_q, s1_vs_q, s1_hit_q;
  logic [PW-1:0] s1_pix_q;
  logic          de_o_q, hs_o_q, vs_o_q;
  logic [PW-1:0] pix_o_q;

  logic [SW-1:0]      sum_c;
  logic [COLOR_W-1:0] sel_c;
  logic vs_rise_c, de_fall_c, obj_c;
  logic in_x_c, in_y_c, edge_c, hit_c;

  assign vs_rise_c = v_sync_in & ~vs_q;
  assign de_fall_c = ~de_in & de_q;
  // A pixel arriving on the frame-start edge belongs to line 0
  assign y_c = vs_rise_c ? '0 : y_q;

  assign sum_c = SW'(pixel_in[2*COLOR_W +: COLOR_W])
               + SW'(pixel_in[COLOR_W +: COLOR_W])
               + SW'(pixel_in[0 +: COLOR_W]);

  always_comb begin
    sel_c = '0;
    case (mode)
      2'd0:    sel_c = pixel_in[2*COLOR_W +: COLOR_W];
      2'd1:    sel_c = pixel_in[COLOR_W +: COLOR_W];
      2'd2:    sel_c = pixel_in[0 +: COLOR_W];
      default: sel_c = COLOR_W'((sum_c * SW'(85)) >> 8);
    endcase
  end

  assign obj_c = de_in && (sel_c >= THRESH);

  assign in_x_c = (x_q >= lx0_q) && (x_q <= lx1_q);
  assign in_y_c = (y_c >= ly0_q) && (y_c <= ly1_q);
  assign edge_c =
    ((x_q == lx0_q || x_q == lx1_q) && in_y_c) ||
    ((y_c == ly0_q || y_c == ly1_q) && in_x_c);

`ifdef VP_BBOX_CROSS_EN
  logic cross_c;
  assign cross_c = in_x_c && in_y_c && (
    (x_q == XW'(({1'b0, lx0_q} + {1'b0, lx1_q}) >> 1)) ||
    (y_c == YW'(({1'b0, ly0_q} + {1'b0, ly1_q}) >> 1)));
  assign hit_c = de_in && valid_q && (edge_c || cross_c);
`else
  assign hit_c = de_in && valid_q && edge_c;
`endif

  always_comb begin
    x_d = de_in ? ((x_q == X_LAST) ? x_q : x_q + XW'(1)) : '0;
    y_d = y_q;
    if (vs_rise_c)
      y_d = '0;
    else if (de_fall_c && y_q != Y_LAST)
      y_d = y_q + YW'(1);

    found_d = found_q;
    rx0_d = rx0_q; rx1_d = rx1_q;
    ry0_d = ry0_q; ry1_d = ry1_q;
    valid_d = valid_q;
    lx0_d = lx0_q; lx1_d = lx1_q;
    ly0_d = ly0_q; ly1_d = ly1_q;

    // Latch the finished frame before this cycle's pixel is counted
    if (vs_rise_c) begin
      valid_d = found_q;
      if (found_q) begin
        lx0_d = rx0_q; lx1_d = rx1_q;
        ly0_d = ry0_q; ly1_d = ry1_q;
      end
      found_d = 1'b0;
      rx0_d = '0; rx1_d = '0;
      ry0_d = '0; ry1_d = '0;
    end

    if (obj_c) begin
      if (!found_d) begin
        rx0_d = x_q; rx1_d = x_q;
        ry0_d = y_c; ry1_d = y_c;
      end else begin
        if (x_q < rx0_d) rx0_d = x_q;
        if (x_q > rx1_d) rx1_d = x_q;
        if (y_c < ry0_d) ry0_d = y_c;
        if (y_c > ry1_d) ry1_d = y_c;
      end
      found_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de_q <= 1'b0; vs_q <= 1'b0;
      x_q <= '0; y_q <= '0;
      found_q <= 1'b0;
      rx0_q <= '0; rx1_q <= '0;
      ry0_q <= '0; ry1_q <= '0;
      valid_q <= 1'b0;
      lx0_q <= '0; lx1_q <= '0;
      ly0_q <= '0; ly1_q <= '0;
      s1_de_q <= 1'b0; s1_hs_q <= 1'b0;
      s1_vs_q <= 1'b0; s1_hit_q <= 1'b0;
      s1_pix_q <= '0;
      de_o_q <= 1'b0; hs_o_q <= 1'b0;
      vs_o_q <= 1'b0; pix_o_q <= '0;
    end else begin
      de_q <= de_in; vs_q <= v_sync_in;
      x_q <= x_d; y_q <= y_d;
      found_q <= found_d;
      rx0_q <= rx0_d; rx1_q <= rx1_d;
      ry0_q <= ry0_d; ry1_q <= ry1_d;
      valid_q <= valid_d;
      lx0_q <= lx0_d; lx1_q <= lx1_d;
      ly0_q <= ly0_d; ly1_q <= ly1_d;
      s1_de_q <= de_in; s1_hs_q <= h_sync_in;
      s1_vs_q <= v_sync_in; s1_hit_q <= hit_c;
      s1_pix_q <= pixel_in;
      de_o_q <= s1_de_q; hs_o_q <= s1_hs_q;
      vs_o_q <= s1_vs_q;
      pix_o_q <= s1_hit_q ? RED : s1_pix_q;
    end
  end

  assign de_out = de_o_q;
  assign h_sync_out = hs_o_q;
  assign v_sync_out = vs_o_q;
  assign pixel_out = pix_o_q;
  assign bbox_valid = valid_q;
  assign x_min = lx0_q;
  assign x_max = lx1_q;
  assign y_min = ly0_q;
  assign y_max = ly1_q;

endmodule

// File: doc/vp_bbox_overlay.md
VP_BBOX_OVERLAY -- requirements
Module: vp_bbox_overlay

Interface
REQ-001 The block SHALL expose parameter H_ACT, default 64, meaning active pixels per line.
REQ-002 The block SHALL expose parameter V_ACT, default 64, meaning active lines per frame.
REQ-003 The block SHALL expose parameter COLOR_W, default 8, meaning bits per colour channel.
REQ-004 The block SHALL expose parameter THRESH, default 128, meaning the object detection threshold, COLOR_W bits wide.
REQ-005 The block SHALL use one clock and a synchronous, active-low reset, with ports clk and rst_n.
REQ-006 clk  input  1  pixel clock; every register samples on its rising edge.
REQ-007 rst_n  input  1  synchronous reset, active low.
REQ-008 de_in, h_sync_in, v_sync_in  input  1 each  video timing inputs.
REQ-009 pixel_in  input  3*COLOR_W  pixel as {R,G,B}.
REQ-010 mode  input  2  detection channel select: 0=R, 1=G, 2=B, 3=mean of channels, computed as (R+G+B) multiplied by 85 then shifted right by 8.
REQ-011 de_out, h_sync_out, v_sync_out  output  1 each  timing outputs, delayed to match pixel_out.
REQ-012 pixel_out  output  3*COLOR_W  video with the bounding-box overlay applied.
REQ-013 bbox_valid  output  1  high when the previous frame contained at least one object pixel.
REQ-014 x_min, x_max  output  clog2(H_ACT) each  latched horizontal bounds; y_min, y_max  output  clog2(V_ACT) each  latched vertical bounds.

Function
REQ-015 All timing signals and pixel_out SHALL have a fixed latency of exactly 2 clk cycles from input to output.
REQ-016 The x counter SHALL increment on each de_in=1 cycle, saturate at H_ACT-1, and clear on the cycle after de_in falls.
REQ-017 The y counter SHALL increment on each de_in falling edge, saturate at V_ACT-1, and clear on the v_sync_in rising edge.
REQ-018 A pixel SHALL be an object pixel when de_in=1 and the mode-selected value is greater than or equal to THRESH.
REQ-019 Running bounds SHALL track the min and max x/y of object pixels; the first object pixel of a frame SHALL load all four bounds.
REQ-020 On the v_sync_in rising edge, the block SHALL copy the running bounds to x_min..y_max, set bbox_valid to the found flag, and clear the running state; when the found flag is 0, the latched bounds SHALL keep their old values.
REQ-021 When the frame-start edge and an object pixel occur in the same cycle, the latch SHALL use the old running state, and the pixel SHALL seed the new frame.
REQ-022 When bbox_valid=1, pixel_out SHALL be set to {all ones, zero, zero} (pure red) on pixels on the rectangle edge: (x==x_min or x==x_max) with y_min<=y<=y_max, or (y==y_min or y==y_max) with x_min<=x<=x_max.
REQ-023 All other pixels SHALL pass through unchanged; pixels with de=0 SHALL pass through unchanged.
REQ-024 The overlay SHALL use the latched bounds, so the box drawn in frame N SHALL come from frame N-1.

Reset
REQ-025 While rst_n=0 at a clk edge, all outputs, the counters, the running bounds and the pipeline SHALL be cleared to 0.
REQ-026 A reset asserted mid-frame SHALL discard the partial frame; after release, the first v_sync_in rising edge SHALL latch bbox_valid=0 unless object pixels were seen after reset.

Configuration
REQ-027 With macro VP_BBOX_CROSS_EN defined, the block SHALL also paint red the pixels where x==(x_min+x_max)>>1 or y==(y_min+y_max)>>1, restricted to inside the box, when bbox_valid=1.
REQ-028 Without VP_BBOX_CROSS_EN, the block SHALL draw only the rectangle outline and SHALL contain no crosshair logic.

Verification
(All scenarios use H_ACT=8, V_ACT=6, THRESH=128, mode=0, unless stated otherwise.)
REQ-029 Single red pixel 200 at (3,2) in frame 1 -> at frame 2 start: bbox_valid=1, x_min=x_max=3, y_min=y_max=2; frame 2 output pixel (3,2)=FF0000, all other pixels unchanged.
REQ-030 Object pixels at (1,1) and (6,4) -> bounds 1/6/1/4; frame 2 outline painted red, interior pixel (3,3) unchanged.
REQ-031 All-black frame after a valid frame -> bbox_valid=0, bounds unchanged, frame output identical to input delayed by 2 cycles.
REQ-032 mode=3 with pixel {150,150,150} -> detected; mode=3 with {255,0,0}, mean 84 -> not detected.
REQ-033 rst_n pulsed low for 1 cycle mid-frame 1 -> all outputs 0 the next cycle; frame 2 start latches bbox_valid=0.
REQ-034 With VP_BBOX_CROSS_EN defined and box 0/6/0/4 -> pixels on x=3 and on y=2 inside the box red; without the macro, (3,2) passes through unchanged.
